down_counter_timer: RTL and testbench
=====================================

# down_counter_timer

Synchronous, loadable, parameterised down counter with a valid/ready load handshake and a one-cycle terminal-count pulse. It is the counting-down counterpart to the team's ripple up counter: software or an upstream block loads a start value, and the block counts it down to zero under an enable. It sits beside the up counter in the counter/timer examples and serves as a programmable delay or divider.

## Interface
Parameters:
- `N`, default 4: counter width in bits.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset; sampled on the rising edge of `clk` only.
- `load_valid`  in  1  a load value is offered.
- `load_ready`  out  1  the block can accept a load; high exactly when the state is `IDLE`.
- `load_value`  in  N  start value; sampled on the handshake.
- `en`  in  1  count enable; takes effect in `RUN` only.
- `q`  out  N  current count, registered.
- `busy`  out  1  high when the state is `RUN`.
- `tc`  out  1  terminal-count pulse, registered, one cycle wide.

## Operation
- The state machine has two states, `IDLE` and `RUN`.
- **Load handshake:**
  - A load occurs on any rising edge with `load_valid && load_ready`.
  - `load_ready` is a combinational decode of the state (`IDLE`) and does not depend on `load_valid`.
- **IDLE:**
  - `q` holds its value and `en` is ignored.
  - On a load with `load_value != 0`: `q <= load_value`, state goes to `RUN`.
  - On a load with `load_value == 0`: `q <= 0`, `tc <= 1`, state stays `IDLE`.
- **RUN:**
  - `en == 0`: `q` holds.
  - `en == 1` and `q > 1`: `q <= q - 1`.
  - `en == 1` and `q == 1`: `q <= 0`, `tc <= 1`, state goes to `IDLE`.
  - `load_valid` is ignored; `load_ready` is 0.
- **Terminal count:** `tc` is 0 on every cycle other than the one following the terminal event. There is never back-to-back `tc` without an intervening load.
- **Arithmetic:** modulo 2^N, unsigned. `q` never wraps below 0, because the `RUN` exit is taken at `q == 1`.
- **Maximum load:** `load_value = 2^N-1` (all ones) is legal and takes 2^N-1 enabled cycles to reach 0.
- **Reload register:** `reload_val` (N bits) captures `load_value` on every load. It is used only when `DOWN_CNT_AUTORELOAD_EN` is defined.

## Timing
- **Reset values:** `q = 0`, `tc = 0`, `busy = 0`, `load_ready = 1`, state `IDLE`, `reload_val = 0`.
- **Reset priority:** reset has priority over load, `en` and terminal count. Reset asserted mid-`RUN` returns to `IDLE` on that edge with no `tc`.
- **Load latency:** load accepted at edge k gives `q = load_value` and `busy = 1` after edge k.
- **Count latency:** with `en` held high from edge k+1, `q` reaches 0 and `tc = 1` after edge k+V, where V = `load_value`. The value `busy` falls to 0 on that same edge, and `load_ready` rises with it.
- **Earliest reload:** a new load can be accepted on edge k+V+1, the cycle in which `tc` is high.
- **Zero load:** a load of 0 at edge k gives `tc = 1` after edge k. `busy` stays 0 throughout.
- **Enable gaps:** gaps in `en` stretch the countdown by exactly the number of disabled cycles.

## Configuration
- Macro: `DOWN_CNT_AUTORELOAD_EN`.
- **Defined:** in `RUN` with `en == 1` and `q == 1`:
  - `q <= reload_val`, `tc <= 1`, state stays `RUN`.
  - The result is a periodic `tc` with period `reload_val` enabled cycles.
  - Exit from `RUN` is by `reset` only.
  - A zero load still behaves as one-shot.
- **Undefined:** one-shot behaviour exactly as in Operation. `reload_val` and its logic are not instantiated.

## Structure
- **Shared package `counter_pkg`:**
  - state enum `dcnt_state_t` {`IDLE`, `RUN`}.
  - localparam `DCNT_DEFAULT_N = 4`.
- **Sub-module `dcnt_stage`:** one per bit, generated N times.
  - Each stage is a synchronous-reset toggle flop with parallel load.
  - Bit i toggles when the decrement is enabled and all lower bits are 0 (borrow chain).
  - This is the synchronous dual of the up counter's T-flop chain.
  - The state machine, `tc`, and `reload_val` live in `down_counter_timer`.

## Test plan
- Reset, then idle 5 cycles -> `q = 0`, `tc = 0`, `busy = 0`, `load_ready = 1` on every cycle.
- Load 4'd5, `en = 1` continuously -> `q` = 5,4,3,2,1,0 on consecutive cycles; `tc = 1` only with `q = 0`; `busy` falls on that same cycle.
- Load 4'd3, `en` pattern 1,0,0,1,1 -> `q` = 3,2,2,2,1,0; `tc` on the final cycle; `load_valid` held high during `RUN` is ignored.
- Load 4'd0 -> `tc = 1` the next cycle; `busy` stays 0; `load_ready` stays 1.
- Load 4'd15, assert `reset` when `q = 9` -> next cycle `q = 0`, `busy = 0`, `tc = 0`; a new load of 4'd2 yields `tc` 2 cycles later.
- With `DOWN_CNT_AUTORELOAD_EN` defined, load 4'd3, `en = 1` -> `q` = 3,2,1,3,2,1,...; `tc = 1` on each cycle where `q` reloads to 3; `busy` stays 1.

Source files
------------

// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared types and constants for the down counter/timer.
//
// Contents:
//   dcnt_state_t    : state enum {IDLE, RUN}
//   DCNT_DEFAULT_N  : default counter width in bits

package counter_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } dcnt_state_t;

   localparam int DCNT_DEFAULT_N = 4;

endpackage

// File: rtl/dcnt_stage.sv
// rtl/dcnt_stage.sv - one bit of the down counter: synchronous toggle flop with parallel load.
//
// Ports:
//   clk    in  rising-edge clock
//   reset  in  synchronous active-high reset, clears q
//   load   in  parallel load strobe, takes d (priority over toggle)
//   d      in  parallel load data
//   toggle in  invert q on this edge (borrow chain term from the top)
//   q      out registered bit value

module dcnt_stage
   import counter_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic d,
   input  logic toggle,
   output logic q
);

   always_ff @(posedge clk) begin
      if (reset) begin
         q <= 1'b0;
      end else if (load) begin
         q <= d;
      end else if (toggle) begin
         q <= ~q;
      end
   end

endmodule

// File: rtl/down_counter_timer.sv
// rtl/down_counter_timer.sv - loadable down counter with valid/ready load and one-cycle terminal-count pulse.
//
// Build option: define DOWN_CNT_AUTORELOAD_EN to reload q from reload_val at terminal
// count and stay in RUN (periodic tc); otherwise the counter is one-shot.
//
// Ports:
//   clk         in  rising-edge clock
//   reset       in  synchronous active-high reset
//   load_valid  in  a load value is offered
//   load_ready  out high exactly when the state is IDLE
//   load_value  in  [N-1:0] start value, sampled on the handshake
//   en          in  count enable, effective in RUN only
//   q           out [N-1:0] current count, registered
//   busy        out high when the state is RUN
//   tc          out registered terminal-count pulse, one cycle wide

module down_counter_timer
   import counter_pkg::*;
#(
   parameter int N = DCNT_DEFAULT_N
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load_valid,
   output logic         load_ready,
   input  logic [N-1:0] load_value,
   input  logic         en,
   output logic [N-1:0] q,
   output logic         busy,
   output logic         tc
);

   dcnt_state_t  state;
   logic         take_load;
   logic         run_en;
   logic         at_one;
   logic         dec_en;
   logic         stage_load;
   logic [N-1:0] stage_d;
   logic [N-1:0] lower_zero;

   assign load_ready = (state == IDLE);
   assign busy       = (state == RUN);
   assign take_load  = load_valid && load_ready;
   assign run_en     = (state == RUN) && en;
   assign at_one     = (q == N'(1));

`ifdef DOWN_CNT_AUTORELOAD_EN
   logic [N-1:0] reload_val;

   always_ff @(posedge clk) begin
      if (reset) begin
         reload_val <= '0;
      end else if (take_load) begin
         reload_val <= load_value;
      end
   end

   // take_load and run_en are exclusive (IDLE vs RUN), so the mux select is unambiguous.
   assign stage_load = take_load || (run_en && at_one);
   assign stage_d    = take_load ? load_value : reload_val;
   assign dec_en     = run_en && !at_one;
`else
   // Decrementing 1 yields 0, so the terminal step is an ordinary decrement.
   assign stage_load = take_load;
   assign stage_d    = load_value;
   assign dec_en     = run_en;
`endif

   // Borrow chain: bit i flips when every lower bit is already 0.
   assign lower_zero[0] = 1'b1;

   genvar i;
   generate
      for (i = 1; i < N; i++) begin : g_borrow
         assign lower_zero[i] = lower_zero[i-1] & ~q[i-1];
      end

      for (i = 0; i < N; i++) begin : g_stage
         dcnt_stage u_stage (
            .clk    (clk),
            .reset  (reset),
            .load   (stage_load),
            .d      (stage_d[i]),
            .toggle (dec_en & lower_zero[i]),
            .q      (q[i])
         );
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         tc    <= 1'b0;
      end else begin
         tc <= 1'b0;
         case (state)
            IDLE: begin
               if (take_load) begin
                  if (load_value != '0) begin
                     state <= RUN;
                  end else begin
                     tc <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (run_en && at_one) begin
                  tc <= 1'b1;
`ifndef DOWN_CNT_AUTORELOAD_EN
                  state <= IDLE;
`endif
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_down_counter_timer.sv
// tb/tb_down_counter_timer.sv - scoreboard testbench for down_counter_timer (N = 4).

module tb_down_counter_timer;

   logic       clk;
   logic       reset;
   logic       load_valid;
   logic       load_ready;
   logic [3:0] load_value;
   logic       en;
   logic [3:0] q;
   logic       busy;
   logic       tc;

   typedef struct {
      int         id;
      logic [3:0] q;
      logic       tc;
      logic       busy;
      logic       rdy;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   step_id = 0;

   down_counter_timer #(.N(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_value (load_value),
      .en         (en),
      .q          (q),
      .busy       (busy),
      .tc         (tc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle of inputs and queue the outputs expected after the next rising edge.
   task automatic step(input logic r, input logic lv, input logic [3:0] val, input logic e,
                       input logic [3:0] eq, input logic etc, input logic eb);
      exp_t x;
      @(negedge clk);
      reset      = r;
      load_valid = lv;
      load_value = val;
      en         = e;
      x.id   = step_id;
      x.q    = eq;
      x.tc   = etc;
      x.busy = eb;
      x.rdy  = ~eb;
      exp_q.push_back(x);
      step_id++;
   endtask

   // Monitor: every cycle the DUT presents a fresh output; compare against the queue head.
   always @(posedge clk) begin
      exp_t x;
      #2;
      if (exp_q.size() > 0) begin
         x = exp_q.pop_front();
         checks++;
         if (q !== x.q || tc !== x.tc || busy !== x.busy || load_ready !== x.rdy) begin
            errors++;
            $display("FAIL step%0d: got q=%0d tc=%0b busy=%0b rdy=%0b, want q=%0d tc=%0b busy=%0b rdy=%0b",
                     x.id, q, tc, busy, load_ready, x.q, x.tc, x.busy, x.rdy);
         end
      end
   end

   initial begin
      reset      = 1'b1;
      load_valid = 1'b0;
      load_value = 4'd0;
      en         = 1'b0;

      // Reset, then idle five cycles.
      step(1, 0, 4'd0, 0, 4'd0, 0, 0);
      step(1, 1, 4'd7, 1, 4'd0, 0, 0);
      for (int i = 0; i < 5; i++) step(0, 0, 4'd0, 1, 4'd0, 0, 0);

`ifdef DOWN_CNT_AUTORELOAD_EN
      // Load 3 with en held: 3,2,1,3(tc),2,1,3(tc); busy stays high.
      step(0, 1, 4'd3, 1, 4'd3, 0, 1);
      step(0, 0, 4'd0, 1, 4'd2, 0, 1);
      step(0, 0, 4'd0, 1, 4'd1, 0, 1);
      step(0, 0, 4'd0, 1, 4'd3, 1, 1);
      step(0, 1, 4'd9, 1, 4'd2, 0, 1);
      step(0, 0, 4'd0, 1, 4'd1, 0, 1);
      step(0, 0, 4'd0, 1, 4'd3, 1, 1);
      step(0, 0, 4'd0, 0, 4'd3, 0, 1);
      step(1, 0, 4'd0, 1, 4'd0, 0, 0);
      // Zero load stays one-shot.
      step(0, 1, 4'd0, 1, 4'd0, 1, 0);
      step(0, 0, 4'd0, 1, 4'd0, 0, 0);
`else
      // Load 5, en continuous: 5,4,3,2,1,0 with tc and busy fall on the last.
      step(0, 1, 4'd5, 1, 4'd5, 0, 1);
      step(0, 0, 4'd0, 1, 4'd4, 0, 1);
      step(0, 0, 4'd0, 1, 4'd3, 0, 1);
      step(0, 0, 4'd0, 1, 4'd2, 0, 1);
      step(0, 0, 4'd0, 1, 4'd1, 0, 1);
      step(0, 0, 4'd0, 1, 4'd0, 1, 0);
      // Earliest reload in the tc cycle: load 3, en 1,0,0,1,1, load_valid held in RUN.
      step(0, 1, 4'd3, 1, 4'd3, 0, 1);
      step(0, 1, 4'd7, 1, 4'd2, 0, 1);
      step(0, 1, 4'd7, 0, 4'd2, 0, 1);
      step(0, 1, 4'd7, 0, 4'd2, 0, 1);
      step(0, 1, 4'd7, 1, 4'd1, 0, 1);
      step(0, 1, 4'd7, 1, 4'd0, 1, 0);
      step(0, 0, 4'd0, 1, 4'd0, 0, 0);
      // Zero load.
      step(0, 1, 4'd0, 1, 4'd0, 1, 0);
      step(0, 0, 4'd0, 1, 4'd0, 0, 0);
      step(0, 0, 4'd0, 0, 4'd0, 0, 0);
      // Load 15, reset at q = 9, then load 2.
      step(0, 1, 4'd15, 0, 4'd15, 0, 1);
      for (int v = 14; v >= 9; v--) step(0, 0, 4'd0, 1, 4'(v), 0, 1);
      step(1, 1, 4'd6, 1, 4'd0, 0, 0);
      step(0, 1, 4'd2, 1, 4'd2, 0, 1);
      step(0, 0, 4'd0, 1, 4'd1, 0, 1);
      step(0, 0, 4'd0, 1, 4'd0, 1, 0);
      step(0, 0, 4'd0, 1, 4'd0, 0, 0);
      // Full-range load 15 down to 0.
      step(0, 1, 4'd15, 1, 4'd15, 0, 1);
      for (int v = 14; v >= 1; v--) step(0, 0, 4'd0, 1, 4'(v), 0, 1);
      step(0, 0, 4'd0, 1, 4'd0, 1, 0);
      step(0, 0, 4'd0, 0, 4'd0, 0, 0);
`endif

      // Allow the monitor to drain, bounded.
      for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
      #4;
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
